// File: rtl/grad_descent_engine.sv
// Fixed-point gradient-descent sequencer driving an external evaluator; an iteration costs LAUNCH + WAIT (>=1) + UPDATE.
// The evaluator paces the loop through eval_done; a finished run stays in DONE until start_op is dropped.
module grad_descent_engine #(
    parameter int                DATA_W         = 32,
    parameter int                FRAC_W         = 8,
    parameter int                NUM_ITERATIONS = 10,
    parameter logic [DATA_W-1:0] LEARNING_RATE  = 32'h00000080,
    parameter logic [DATA_W-1:0] GRAD_TOL       = '0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start_op,
    input  logic signed [DATA_W-1:0]                x_init,
    output logic                                    eval_start,
    output logic signed [DATA_W-1:0]                eval_x,
    input  logic                                    eval_done,
    input  logic signed [DATA_W-1:0]                eval_grad,
    input  logic signed [2*DATA_W-1:0]              eval_value,
    input  logic                                    eval_ovf,
    output logic signed [DATA_W-1:0]                x_at_min,
    output logic signed [2*DATA_W-1:0]              y_min,
    output logic [$clog2(NUM_ITERATIONS+1)-1:0]     iter_used,
    output logic                                    converged,
    output logic                                    err_ovf,
    output logic                                    busy,
    output logic                                    done_op
);

    localparam int ITER_W = $clog2(NUM_ITERATIONS + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(NUM_ITERATIONS);

    localparam logic signed [DATA_W-1:0]   X_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0]   X_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [2*DATA_W-1:0] Y_MAX = {1'b0, {(2*DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        UPDATE,
        DONE
    } state_t;

    state_t                      state;
    logic signed [DATA_W-1:0]    x_cur;
    logic signed [DATA_W-1:0]    grad_q;
    logic signed [2*DATA_W-1:0]  value_q;
    logic                        ovf_q;

    logic signed [2*DATA_W-1:0]  lr_ext;
    logic signed [2*DATA_W-1:0]  grad_ext;
    logic signed [2*DATA_W-1:0]  prod;
    logic signed [2*DATA_W-1:0]  step;
    logic        [2*DATA_W:0]    diff;
    logic signed [DATA_W-1:0]    x_next;
    logic signed [DATA_W-1:0]    grad_abs;
    logic                        grad_ok;
    logic                        better;
    logic                        last_iter;

    assign eval_x = x_cur;

    // The product cannot exceed 2*DATA_W signed bits, so the step is exact before the floor shift.
    always_comb begin
        lr_ext   = {{DATA_W{1'b0}}, LEARNING_RATE};
        grad_ext = {{DATA_W{grad_q[DATA_W-1]}}, grad_q};
        prod     = lr_ext * grad_ext;
        step     = prod >>> FRAC_W;
        diff     = {x_cur[DATA_W-1], {DATA_W{x_cur[DATA_W-1]}}, x_cur}
                 - {step[2*DATA_W-1], step};
        if (diff[2*DATA_W:DATA_W-1] == {(DATA_W+2){diff[2*DATA_W]}}) begin
            x_next = diff[DATA_W-1:0];
        end else begin
            x_next = diff[2*DATA_W] ? X_MIN : X_MAX;
        end

        if (grad_q == X_MIN) begin
            grad_abs = X_MAX;
        end else if (grad_q[DATA_W-1]) begin
            grad_abs = -grad_q;
        end else begin
            grad_abs = grad_q;
        end
        grad_ok   = $unsigned(grad_abs) <= GRAD_TOL;
        better    = value_q < y_min;
        last_iter = iter_used == ITER_LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_cur      <= '0;
            grad_q     <= '0;
            value_q    <= '0;
            ovf_q      <= 1'b0;
            eval_start <= 1'b0;
            x_at_min   <= '0;
            y_min      <= '0;
            iter_used  <= '0;
            converged  <= 1'b0;
            err_ovf    <= 1'b0;
            busy       <= 1'b0;
            done_op    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_op) begin
                        x_cur      <= x_init;
                        x_at_min   <= x_init;
                        y_min      <= Y_MAX;
                        iter_used  <= '0;
                        converged  <= 1'b0;
                        err_ovf    <= 1'b0;
                        eval_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    eval_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (eval_done) begin
                        grad_q    <= eval_grad;
                        value_q   <= eval_value;
                        ovf_q     <= eval_ovf;
                        iter_used <= iter_used + 1'b1;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    // An overflowed evaluation is never allowed to become the minimum.
                    if (ovf_q) begin
                        err_ovf <= 1'b1;
                        busy    <= 1'b0;
                        done_op <= 1'b1;
                        state   <= DONE;
                    end else begin
                        if (better) begin
                            y_min    <= value_q;
                            x_at_min <= x_cur;
                        end
                        if (grad_ok) begin
                            converged <= 1'b1;
                            busy      <= 1'b0;
                            done_op   <= 1'b1;
                            state     <= DONE;
                        end else if (last_iter) begin
                            busy    <= 1'b0;
                            done_op <= 1'b1;
                            state   <= DONE;
                        end else begin
                            x_cur      <= x_next;
                            eval_start <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                end
                DONE: begin
                    if (!start_op) begin
                        done_op <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
